loopback_engine: RTL and testbench
==================================

# loopback_engine

Parametrised loopback and link-test engine for the tile I/O path. It supports four modes: registered pass-through, a configurable delay line, PRBS pattern generation, and PRBS generate-and-check with an error counter. In check mode the pads are looped back externally, and the engine verifies that the link returns the pattern after exactly DEPTH cycles. It sits between the tile's dedicated input and output buses and can replace a purely combinational loopback when cycle-accurate link testing is needed.

## Interface
- WIDTH, 8, data width of `din`/`dout`; 1..16
- DEPTH, 4, delay-line stages and expected external loop latency in cycles; ≥1
- CNT_W, 8, error counter width; ≥1
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous active-high
- ena  in  1  clock enable; low = every register holds
- mode  in  2  0 PASS, 1 DELAY, 2 GEN, 3 CHECK
- clr_err  in  1  synchronous clear of `err_cnt` and `err_sticky`
- din  in  WIDTH  data/loopback input
- dout  out  WIDTH  data/pattern output
- checking  out  1  comparison active this cycle
- err_pulse  out  1  registered: mismatch detected on previous enabled cycle
- err_sticky  out  1  set by any mismatch, cleared by rst/clr_err
- err_cnt  out  CNT_W  saturating mismatch count

## Operation
- Registers: `pass_q[WIDTH]`; delay line `dl[0..DEPTH-1][WIDTH]`; `lfsr[15:0]`; warm-up counter `warm` (0..DEPTH); `mode_q`; `err_cnt`; `err_sticky`; `err_pulse`.
- Reset: `pass_q`=0, all `dl`=0, `lfsr`=16'hACE1, `warm`=0, `mode_q`=0, `err_cnt`=0, `err_sticky`=0, `err_pulse`=0.
- All updates below occur only on cycles with `ena`=1 and `rst`=0. `rst` overrides `ena`.
- LFSR: 16-bit Galois, polynomial 16'hB400, right-shifting. Next state = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It advances each enabled cycle while mode ∈ {2,3} and holds otherwise.
- Delay-line input is `din` in modes 0/1 and `lfsr[WIDTH-1:0]` in modes 2/3. `dl[0]` ← input and `dl[i]` ← `dl[i-1]` every enabled cycle, in all modes.
- `pass_q` ← `din` every enabled cycle.
- `dout` mux (combinational from registers):
  - PASS → `pass_q`
  - DELAY → `dl[DEPTH-1]`
  - GEN/CHECK → `lfsr[WIDTH-1:0]`
- `mode_q` ← `mode` every enabled cycle. When `mode` ≠ `mode_q`, `warm` ← 0. Otherwise `warm` increments and saturates at DEPTH.
- `checking` = (`mode`==3) && (`mode_q`==3) && (`warm`==DEPTH).
- mismatch = `checking` && (`din` ≠ `dl[DEPTH-1]`). The comparison is against the pattern driven exactly DEPTH cycles earlier.
- `err_pulse` ← mismatch.
- On mismatch: `err_sticky` ← 1, and `err_cnt` ← `err_cnt`+1, saturating at 2^CNT_W−1 (no wrap).
- `clr_err` has priority over a same-cycle mismatch: `err_cnt`=0 and `err_sticky`=0. `err_pulse` still reflects the mismatch.
- Mode 0/1/2: no checking and the counters hold.

## Timing
- PASS latency: 1 cycle. `dout`(t+1) = `din`(t).
- DELAY latency: DEPTH cycles.
- GEN: `dout` changes the cycle after each enabled edge. After reset with mode=2, the first value is 0xE1 (WIDTH=8) and the next is 0x70.
- CHECK: `checking` rises DEPTH+1 enabled cycles after entering mode 3. This covers 1 cycle for `mode_q` and DEPTH cycles to fill the delay line with pattern.
- `ena` low is a full stall: `dout`, `warm`, the LFSR and the error state are frozen. `err_pulse` holds its last value.
- Reset mid-check: the next cycle shows `checking`=0, `err_cnt`=0, and the LFSR reseeded to ACE1.
- Any mode change, including a one-cycle glitch, restarts warm-up.

## Test plan
- Reset then mode=0, `din`=0x5A at t → `dout`=0x5A at t+1. `checking`=0, `err_cnt`=0 throughout.
- Mode=1, DEPTH=4, `din` ramp 0x01,0x02,… → `dout` shows 0x01 exactly 4 cycles after it is applied. Toggling `ena` low for 3 cycles stretches the latency by 3.
- Reset, mode=2 → `dout` sequence 0xE1, 0x70, …, matching the Galois model for 100 cycles.
- Mode=3 with `din` = `dout` delayed 4 cycles by the bench → `checking` high from the 5th enabled cycle, and `err_cnt`=0 after 1000 cycles.
- Mode=3, loopback with a single bit flipped on 3 cycles → `err_pulse` 3 single-cycle pulses, `err_cnt`=3, `err_sticky`=1. `clr_err` coincident with a 4th error → `err_cnt`=0, `err_sticky`=0.
- CNT_W=2, continuous mismatch (`din`=0 against the pattern) → `err_cnt` saturates at 3 and holds. A mode change to 2 and back to 3 gives `checking`=0 for DEPTH+1 cycles, then checking resumes.

Source files
------------

// File: rtl/loopback_engine.sv
// loopback_engine: registered pass-through, delay line, PRBS generator and
// PRBS generate-and-check with saturating error counter for the tile I/O path.
// In check mode the returned data is compared against the pattern that was
// driven DEPTH enabled cycles earlier, once the delay line is known to hold it.
module loopback_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             checking,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0]        MODE_PASS  = 2'd0;
    localparam logic [1:0]        MODE_DELAY = 2'd1;
    localparam logic [1:0]        MODE_CHECK = 2'd3;
    localparam logic [15:0]       LFSR_SEED  = 16'hACE1;
    localparam logic [15:0]       LFSR_POLY  = 16'hB400;
    localparam int                WARM_W     = $clog2(DEPTH + 1);
    localparam logic [WARM_W-1:0] WARM_MAX   = WARM_W'(DEPTH);

    logic [WIDTH-1:0]  pass_q, pass_d;
    logic [WIDTH-1:0]  dl_q [DEPTH];
    logic [WIDTH-1:0]  dl_d [DEPTH];
    logic [15:0]       lfsr_q, lfsr_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_sticky_q, err_sticky_d;
    logic              err_pulse_q, err_pulse_d;
    logic [WIDTH-1:0]  dl_in;
    logic              mismatch;

    // Next-state for every register; mode bit 1 selects the PRBS modes (GEN/CHECK).
    always_comb begin
        pass_d       = din;
        mode_d       = mode;
        lfsr_d       = lfsr_q;
        warm_d       = warm_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;

        if (mode[1]) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
        end

        dl_in    = mode[1] ? lfsr_q[WIDTH-1:0] : din;
        dl_d[0]  = dl_in;
        for (int i = 1; i < DEPTH; i++) begin
            dl_d[i] = dl_q[i-1];
        end

        // Any mode change, even a single-cycle glitch, restarts warm-up.
        if (mode != mode_q) begin
            warm_d = '0;
        end else if (warm_q != WARM_MAX) begin
            warm_d = warm_q + WARM_W'(1);
        end

        checking    = (mode == MODE_CHECK) && (mode_q == MODE_CHECK) && (warm_q == WARM_MAX);
        mismatch    = checking && (din != dl_q[DEPTH-1]);
        err_pulse_d = mismatch;

        // Clear wins over a coincident mismatch; the pulse still reports it.
        if (clr_err) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else if (mismatch) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers: reset dominates, otherwise update only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q       <= '0;
            lfsr_q       <= LFSR_SEED;
            warm_q       <= '0;
            mode_q       <= MODE_PASS;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                dl_q[i] <= '0;
            end
        end else if (ena) begin
            pass_q       <= pass_d;
            lfsr_q       <= lfsr_d;
            warm_q       <= warm_d;
            mode_q       <= mode_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
            err_pulse_q  <= err_pulse_d;
            for (int i = 0; i < DEPTH; i++) begin
                dl_q[i] <= dl_d[i];
            end
        end
    end

    // Output mux follows the live mode input so GEN shows the seed right after reset.
    always_comb begin
        case (mode)
            MODE_PASS:  dout = pass_q;
            MODE_DELAY: dout = dl_q[DEPTH-1];
            default:    dout = lfsr_q[WIDTH-1:0];
        endcase
    end

    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_loopback_engine.sv
// Directed bench for loopback_engine: scoreboard queues hold expected outputs
// pushed at stimulus time and popped when the DUT should present them.
module tb_loopback_engine;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ena, clr_err;
    logic [1:0] mode, mode2;
    logic [7:0] din, din2;
    logic [7:0] dout, dout2;
    logic       checking, checking2, err_pulse, err_pulse2, err_sticky, err_sticky2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  sbq [$];
    logic        pq  [$];
    logic [7:0]  hist[$];
    logic [15:0] m_lfsr;
    logic [7:0]  exp_v, last_v;
    logic        exp_p, flip;
    logic [7:0]  pv [4] = '{8'h5A, 8'hA5, 8'h3C, 8'hFF};

    loopback_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .clr_err(clr_err), .din(din),
        .dout(dout), .checking(checking), .err_pulse(err_pulse),
        .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    loopback_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode2), .clr_err(clr_err), .din(din2),
        .dout(dout2), .checking(checking2), .err_pulse(err_pulse2),
        .err_sticky(err_sticky2), .err_cnt(err_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] galois(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; clr_err = 1'b0;
        mode = 2'd0; mode2 = 2'd0; din = 8'h00; din2 = 8'h00;
        tick(); tick();
        chk("rst_dout",     32'(dout),       32'h00);
        chk("rst_checking", 32'(checking),   32'h0);
        chk("rst_err_cnt",  32'(err_cnt),    32'h00);
        chk("rst_sticky",   32'(err_sticky), 32'h0);
        chk("rst_pulse",    32'(err_pulse),  32'h0);

        // PASS: one-cycle latency
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = pv[i];
            sbq.push_back(pv[i]);
            tick();
            exp_v = sbq.pop_front();
            chk("pass_dout",     32'(dout),     32'(exp_v));
            chk("pass_checking", 32'(checking), 32'h0);
            chk("pass_err_cnt",  32'(err_cnt),  32'h0);
        end

        // DELAY: DEPTH-cycle latency, stretched by an ena stall
        mode = 2'd1;
        sbq.delete();
        for (int i = 1; i <= 12; i++) begin
            din = 8'(i);
            sbq.push_back(8'(i));
            tick();
            if (sbq.size() == DEPTH) begin
                last_v = sbq.pop_front();
                chk("delay_dout", 32'(dout), 32'(last_v));
                if (i == DEPTH) chk("delay_first", 32'(dout), 32'h01);
            end
        end
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = 8'hEE;
            tick();
            chk("stall_dout", 32'(dout), 32'(last_v));
        end
        ena = 1'b1;
        for (int i = 13; i <= 16; i++) begin
            din = 8'(i);
            sbq.push_back(8'(i));
            tick();
            last_v = sbq.pop_front();
            chk("delay_resume_dout", 32'(dout), 32'(last_v));
        end

        // GEN: Galois sequence from the reset seed
        rst = 1'b1; mode = 2'd2; din = 8'h00;
        tick();
        chk("gen_first", 32'(dout), 32'hE1);
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        sbq.delete();
        for (int i = 0; i < 100; i++) begin
            m_lfsr = galois(m_lfsr);
            sbq.push_back(m_lfsr[7:0]);
            tick();
            exp_v = sbq.pop_front();
            chk("gen_dout", 32'(dout), 32'(exp_v));
            if (i == 0) chk("gen_second", 32'(dout), 32'h70);
        end

        // CHECK: clean loopback delayed DEPTH cycles by the bench
        mode = 2'd3;
        hist.delete();
        for (int k = 1; k <= 1000; k++) begin
            #1;
            hist.push_back(dout);
            din = (hist.size() > DEPTH) ? hist.pop_front() : 8'h00;
            #1;
            if (k <= 12) chk("chk_checking", 32'(checking), 32'(k > DEPTH + 1));
            tick();
        end
        chk("loop_err_cnt",  32'(err_cnt),    32'h0);
        chk("loop_sticky",   32'(err_sticky), 32'h0);
        chk("loop_pulse",    32'(err_pulse),  32'h0);
        chk("loop_checking", 32'(checking),   32'h1);

        // CHECK: three injected single-bit errors
        pq.delete();
        for (int k = 1; k <= 40; k++) begin
            #1;
            flip = (k % 10 == 0) && (k < 40);
            hist.push_back(dout);
            din = hist.pop_front() ^ (flip ? 8'h04 : 8'h00);
            pq.push_back(flip);
            tick();
            exp_p = pq.pop_front();
            chk("inj_pulse", 32'(err_pulse), 32'(exp_p));
        end
        chk("inj_err_cnt", 32'(err_cnt),    32'd3);
        chk("inj_sticky",  32'(err_sticky), 32'h1);

        // clr_err coincident with a fourth error
        #1;
        hist.push_back(dout);
        din = hist.pop_front() ^ 8'h01;
        clr_err = 1'b1;
        tick();
        chk("clr_pulse",   32'(err_pulse),  32'h1);
        chk("clr_err_cnt", 32'(err_cnt),    32'h0);
        chk("clr_sticky",  32'(err_sticky), 32'h0);
        clr_err = 1'b0;
        #1;
        hist.push_back(dout);
        din = hist.pop_front();
        tick();
        chk("post_clr_pulse", 32'(err_pulse), 32'h0);
        chk("post_clr_cnt",   32'(err_cnt),   32'h0);

        // Reset in the middle of checking
        #1;
        hist.push_back(dout);
        din = hist.pop_front() ^ 8'h80;
        tick();
        chk("pre_rst_err_cnt", 32'(err_cnt), 32'h1);
        rst = 1'b1;
        tick();
        chk("rst_mid_checking", 32'(checking),   32'h0);
        chk("rst_mid_err_cnt",  32'(err_cnt),    32'h0);
        chk("rst_mid_sticky",   32'(err_sticky), 32'h0);
        chk("rst_mid_lfsr",     32'(dout),       32'hE1);
        rst = 1'b0;
        mode = 2'd0;

        // Saturation on the CNT_W=2 instance with constant mismatch
        mode2 = 2'd3; din2 = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k >= 12) chk("sat_cnt", 32'(err_cnt2), 32'd3);
        end
        chk("sat_sticky", 32'(err_sticky2), 32'h1);

        // One-cycle mode glitch restarts warm-up
        mode2 = 2'd2;
        #1;
        chk("glitch_checking", 32'(checking2), 32'h0);
        tick();
        mode2 = 2'd3;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk("resume_checking", 32'(checking2), 32'(k > DEPTH + 1));
            tick();
        end
        chk("sat_hold", 32'(err_cnt2), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
